frame_trail_writer: RTL and testbench

Write-side client of the 640-column by 480-row, 1-bit-per-pixel frame RAM. It accepts single-pixel "paint trail" requests from the bike movement logic and performs a read-modify-write on the addressed 480-bit column word. It also provides a full-frame clear sweep for game start. Optionally, it reports collisions when a painted pixel was already set. It owns the frame RAM write port and the read-port address exclusively while busy.

---
 rtl/tron_frame_pkg.sv | 8 +
 rtl/frame_trail_writer.sv | 88 ++++++++
 tb/tb_frame_trail_writer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tron_frame_pkg.sv
// tron_frame_pkg: frame RAM geometry and writer state encoding shared by the trail writer.
package tron_frame_pkg;
    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int X_W = 10;
    localparam int Y_W = 9;
    typedef enum logic [1:0] {IDLE, RD, WR, CLR} state_t;
endpackage

// File: rtl/frame_trail_writer.sv
// frame_trail_writer: read-modify-write pixel painter and full-frame clear for the 1bpp column RAM.
// Define TRAIL_COLLISION_EN to pulse hit_valid when a painted pixel was already set.
module frame_trail_writer #(
    parameter int H_RES  = tron_frame_pkg::H_RES,
    parameter int V_RES  = tron_frame_pkg::V_RES,
    parameter int ADDR_W = 20
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [tron_frame_pkg::X_W-1:0] req_x,
    input  logic [tron_frame_pkg::Y_W-1:0] req_y,
    input  logic                           req_id,
    input  logic                           clear_start,
    output logic                           clear_busy,
    output logic                           wr_done,
    output logic                           hit_valid,
    output logic                           hit_id,
    output logic [ADDR_W-1:0]              ram_read_address,
    input  logic [V_RES-1:0]               ram_data_in,
    output logic [ADDR_W-1:0]              ram_write_address,
    output logic [V_RES-1:0]               ram_data_out,
    output logic                           ram_we
);
    import tron_frame_pkg::*;

    state_t state, state_n;
    logic clear_pend, clr_go, hs, in_range, last, id_q;
    logic [X_W-1:0] x_q, cnt;
    logic [Y_W-1:0] y_q;
    logic [ADDR_W-1:0] wa_q;

    assign clr_go    = clear_pend | clear_start;
    assign req_ready = !Reset && state == IDLE && !clr_go;
    assign hs        = req_valid & req_ready;
    assign in_range  = 32'(req_x) < H_RES && 32'(req_y) < V_RES;
    assign last      = 32'(cnt) == H_RES - 1;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = clr_go ? CLR : (hs && in_range) ? RD : IDLE;
            RD:      state_n = WR;
            WR:      state_n = IDLE;
            CLR:     state_n = last ? IDLE : CLR;
            default: state_n = IDLE;
        endcase
    end

    assign clear_busy        = state == CLR;
    assign wr_done           = state == WR;
    assign ram_we            = state == WR || state == CLR;
    assign ram_read_address  = ADDR_W'(x_q);
    assign ram_write_address = state == WR ? ADDR_W'(x_q) : state == CLR ? ADDR_W'(cnt) : wa_q;
    assign ram_data_out      = state == WR ? ram_data_in | (V_RES'(1) << y_q) : '0;

`ifdef TRAIL_COLLISION_EN
    assign hit_valid = state == WR && ram_data_in[y_q];
    assign hit_id    = hit_valid & id_q;
`else
    assign hit_valid = 1'b0;
    assign hit_id    = 1'b0 & id_q;
`endif

    // A clear requested mid-paint waits until the paint has committed.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            clear_pend <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            id_q       <= 1'b0;
            cnt        <= '0;
            wa_q       <= '0;
        end else begin
            state      <= state_n;
            clear_pend <= (state == RD || state == WR) && clr_go;
            cnt        <= (state == CLR && !last) ? cnt + 1'b1 : '0;
            if (ram_we) wa_q <= ram_write_address;
            if (hs) begin
                x_q  <= req_x;
                y_q  <= req_y;
                id_q <= req_id;
            end
        end
    end
endmodule

// File: tb/tb_frame_trail_writer.sv
// tb_frame_trail_writer: scoreboard bench for frame_trail_writer with a registered-read frame RAM model.
module tb_frame_trail_writer;
    localparam int H = 640;
    localparam int V = 480;
`ifdef TRAIL_COLLISION_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    typedef struct {
        logic [19:0]  addr;
        logic [V-1:0] data;
        bit           paint;
        bit           hit;
        bit           hid;
    } wr_t;

    logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_id = 1'b0, clear_start = 1'b0;
    logic [9:0] req_x = '0;
    logic [8:0] req_y = '0;
    logic req_ready, clear_busy, wr_done, hit_valid, hit_id, ram_we;
    logic [19:0] ram_read_address, ram_write_address;
    logic [V-1:0] ram_data_in, ram_data_out;

    logic [V-1:0] mem [H];
    logic [V-1:0] exp_mem [H];
    wr_t sb[$];
    wr_t e_mon;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    frame_trail_writer dut (
        .Clk(clk), .Reset(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_id(req_id), .clear_start(clear_start),
        .clear_busy(clear_busy), .wr_done(wr_done), .hit_valid(hit_valid), .hit_id(hit_id),
        .ram_read_address(ram_read_address), .ram_data_in(ram_data_in),
        .ram_write_address(ram_write_address), .ram_data_out(ram_data_out), .ram_we(ram_we)
    );

    always @(posedge clk) begin
        ram_data_in <= (ram_read_address < H) ? mem[ram_read_address[9:0]] : '0;
        if (ram_we === 1'b1) mem[ram_write_address[9:0]] <= ram_data_out;
    end

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d, no write expected", ram_write_address);
            end else begin
                e_mon = sb.pop_front();
                if (ram_write_address !== e_mon.addr || ram_data_out !== e_mon.data || wr_done !== e_mon.paint ||
                    hit_valid !== e_mon.hit || (e_mon.hit && hit_id !== e_mon.hid)) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d done=%b hit=%b/%b data=%h expected addr=%0d done=%b hit=%b/%b data=%h",
                             ram_write_address, wr_done, hit_valid, hit_id, ram_data_out,
                             e_mon.addr, e_mon.paint, e_mon.hit, e_mon.hid, e_mon.data);
                end
            end
        end else if (!rst) begin
            n_checks++;
            if (wr_done !== 1'b0 || hit_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_pulse: got wr_done=%b hit_valid=%b expected 0/0", wr_done, hit_valid);
            end
        end
    end

    task automatic push_clear();
        wr_t e;
        for (int i = 0; i < H; i++) begin
            e.addr = 20'(i);
            e.data = '0;
            e.paint = 1'b0;
            e.hit = 1'b0;
            e.hid = 1'b0;
            sb.push_back(e);
            exp_mem[i] = '0;
        end
    endtask

    task automatic paint(input int x, input int y, input bit id, input bit clr_in_wr);
        wr_t e;
        bit ok;
        int w;
        ok = x < H && y < V;
        if (ok) begin
            e.addr = 20'(x);
            e.data = exp_mem[x];
            e.hit = COLL && e.data[y];
            e.hid = id;
            e.data[y] = 1'b1;
            e.paint = 1'b1;
            exp_mem[x] = e.data;
            sb.push_back(e);
        end
        @(negedge clk);
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout: got req_ready=%b expected 1 within 20 cycles", req_ready);
        end
        req_valid = 1'b1;
        req_x = 10'(x);
        req_y = 9'(y);
        req_id = id;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== !ok) begin
            n_fail++;
            $display("FAIL ready_after_handshake x=%0d y=%0d: got %b expected %b", x, y, req_ready, !ok);
        end
        if (ok) begin
            @(negedge clk);
            if (clr_in_wr) clear_start = 1'b1;
            @(negedge clk);
            clear_start = 1'b0;
            n_checks++;
            if (req_ready !== !clr_in_wr) begin
                n_fail++;
                $display("FAIL ready_after_write x=%0d y=%0d: got %b expected %b", x, y, req_ready, !clr_in_wr);
            end
        end else begin
            repeat (3) @(negedge clk);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL paint_drain x=%0d y=%0d: got %0d pending writes expected 0", x, y, sb.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || ram_we !== 1'b0 || clear_busy !== 1'b0 || wr_done !== 1'b0 || hit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b we=%b busy=%b done=%b hit=%b expected all 0",
                     req_ready, ram_we, clear_busy, wr_done, hit_valid);
        end
        n_checks++;
        if (ram_read_address !== 20'd0 || ram_write_address !== 20'd0 || ram_data_out !== '0 || hit_id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_buses: got rd=%0d wr=%0d hit_id=%b expected zeros", ram_read_address, ram_write_address, hit_id);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_clear();
        int busy;
        push_clear();
        @(negedge clk);
        clear_start = 1'b1;
        busy = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            clear_start = (busy == 100);
            if (busy == 300) begin
                n_checks++;
                if (req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ready_during_clear: got %b expected 0", req_ready);
                end
            end
            if (clear_busy === 1'b1) busy++;
            else break;
        end
        n_checks++;
        if (busy != H) begin
            n_fail++;
            $display("FAIL clear_length: got %0d busy cycles expected %0d", busy, H);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_clear: got %b expected 1", req_ready);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (clear_busy !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL clear_no_restart: got busy=%b pending=%0d expected 0/0", clear_busy, sb.size());
        end
    endtask

    task automatic test_paint();
        logic [V-1:0] w;
        w = '0;
        w[10] = 1'b1;
        paint(5, 10, 1'b0, 1'b0);
        n_checks++;
        if (mem[5] !== w) begin
            n_fail++;
            $display("FAIL paint_word: got %h expected %h", mem[5], w);
        end
        paint(0, 0, 1'b1, 1'b0);
        paint(639, 479, 1'b0, 1'b0);
        paint(100, 200, 1'b1, 1'b0);
    endtask

    task automatic test_collision();
        logic [V-1:0] w;
        w = '0;
        w[10] = 1'b1;
        paint(5, 10, 1'b1, 1'b0);
        n_checks++;
        if (mem[5] !== w) begin
            n_fail++;
            $display("FAIL collision_word: got %h expected %h", mem[5], w);
        end
        paint(639, 479, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        paint(5, 11, 1'b0, 1'b0);
        paint(5, 12, 1'b1, 1'b0);
        paint(6, 11, 1'b0, 1'b0);
        paint(5, 11, 1'b1, 1'b0);
    endtask

    task automatic test_out_of_range();
        paint(640, 0, 1'b0, 1'b0);
        paint(0, 480, 1'b1, 1'b0);
        paint(1023, 511, 1'b0, 1'b0);
    endtask

    task automatic test_clear_during_wr();
        int busy;
        paint(3, 7, 1'b0, 1'b1);
        push_clear();
        busy = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (clear_busy === 1'b1) busy++;
            else break;
        end
        n_checks++;
        if (busy != H) begin
            n_fail++;
            $display("FAIL pending_clear_length: got %0d expected %0d", busy, H);
        end
        n_checks++;
        if (mem[3] !== '0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL pending_clear_result: got word3=%h pending=%0d expected 0/0", mem[3], sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int w;
        @(negedge clk);
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1;
        req_x = 10'd9;
        req_y = 9'd1;
        req_id = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        n_checks++;
        if (ram_we !== 1'b0 || wr_done !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got we=%b done=%b ready=%b expected 0/0/0", ram_we, wr_done, req_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || clear_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got ready=%b busy=%b expected 1/0", req_ready, clear_busy);
        end
        paint(9, 1, 1'b1, 1'b0);
    endtask

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int i = 0; i < H; i++) if (mem[i] !== exp_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL memory_image: got %0d differing columns expected 0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < H; i++)
            for (int j = 0; j < V / 32; j++) mem[i][j*32 +: 32] = $urandom;
        test_reset();
        test_clear();
        test_paint();
        test_collision();
        test_back_to_back();
        test_out_of_range();
        test_clear_during_wr();
        test_reset_mid();
        test_memory_image();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
